bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Time-multiplexed controller for a multi-digit 7-segment display.
- Shares a single BCD-to-7-segment decoder across NDIG digits: presents one BCD digit at a time, registers the returned segments, and drives one active-low digit enable per slot.
- Double-buffers the displayed value so that updates take effect only at frame boundaries.
- Optional leading-zero blanking.
- Sits between the numeric datapath and the board display pins.

Parameters:
NDIG, 4, number of digits (2..8); digit NDIG-1 is most significant.
PRESC, 1000, clock cycles each digit is held per scan slot (>=1).

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
load  in  1  one-cycle strobe; captures data into the pending buffer.
data  in  4*NDIG  BCD value; digit i = data[4*i+3:4*i].
lzb  in  1  leading-zero blanking enable (level, sampled every cycle).
dec_d  out  4  BCD digit to the shared decoder (combinational from state).
dec_seg  in  7  decoder segments for dec_d, [0:6] = a..g, active high, combinational path.
seg  out  7  registered segments [0:6], active high.
an  out  NDIG  registered digit enables, active low, at most one bit low.
frame  out  1  one-cycle pulse on each frame wrap.
pending  out  1  high while a loaded value awaits transfer to the display register.

Behaviour:
- State:
  - prescaler cnt (0..PRESC-1)
  - slot index idx (0..NDIG-1)
  - pending buffer buf
  - display register disp
  - pending flag
- Reset values: cnt=0, idx=0, buf=0, disp=0, pending=0, seg=0, an=all 1s (all digits off), frame=0.
- tick = (cnt==PRESC-1). cnt increments every cycle and wraps to 0 on tick; PRESC=1 gives tick every cycle.
- On tick: idx <= (idx==NDIG-1) ? 0 : idx+1.
- wrap = tick && idx==NDIG-1. frame is registered: high exactly the cycle after wrap, for one cycle.
- dec_d = disp digit at idx. Values 10..15 are passed unchanged; the decoder defines their segments.
- Output latency is 1 cycle. Every cycle: seg <= dec_seg and an <= onehot-low(idx), unless the slot is blanked, in which case an <= all 1s and seg <= 0.
- Blanking: slot i is blanked when lzb=1, i!=0, and disp digits NDIG-1..i are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Load:
  - load=1 sets buf <= data and pending <= 1.
  - Repeated loads before a wrap overwrite buf; the last value wins.
- Transfer: on wrap with pending=1, disp <= buf and pending <= 0. The new value appears from slot 0 of the next frame; disp never changes mid-frame.
- Simultaneous load and wrap: disp <= old buf, buf <= new data, pending stays 1. The new data displays one frame later.
- Reset mid-operation: all state returns to reset values on that edge. Pending data is discarded. Outputs are off (an all 1s) for one cycle, then scanning restarts at slot 0.
- No handshake back-pressure: load is always accepted.

Test Plan (NDIG=4, PRESC=4, behavioural decoder model on dec_seg):
1. Reset 2 cycles → seg=0, an=1111, frame=0, pending=0. Next cycle an=1110, dec_d=0. an steps 1110→1101→1011→0111 every 4 cycles; frame pulses once every 16 cycles.
2. load with data=16'h1234 in mid-frame → pending=1 and disp unchanged until wrap. Then pending=0, and in the next frame slots 0..3 show dec_d=4,3,2,1 with seg matching the decoder one cycle after each dec_d.
3. lzb=1, load 16'h0070, wait one frame → slots 3 and 2 have an=1111 and seg=0; slot 1 shows 7; slot 0 shows 0. Load 16'h0000 → only slot 0 is lit, showing 0. lzb=0 → all four slots are lit.
4. Loads of 16'h1111 and 16'h2222 in consecutive cycles before a wrap → next frame displays 2222; 1111 is never shown.
5. load 16'h5555 asserted on the wrap cycle with buf=16'h9999 pending → next frame shows 9999, pending stays 1, and the following frame shows 5555.
6. Assert reset for one cycle while slot 2 is active with pending=1 → the cycle after reset an=1111, pending=0, disp=0; the following cycle an=1110 with dec_d=0. PRESC=1 run: an changes every cycle and frame pulses every 4 cycles.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// Scan controller for an NDIG-digit multiplexed 7-segment display.
// Shares one external BCD decoder, double-buffers the value and optionally blanks leading zeros.
module bcd_scan_ctrl #(
   parameter int unsigned NDIG  = 4,
   parameter int unsigned PRESC = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [4*NDIG-1:0] data,
   input  logic              lzb,
   output logic [3:0]        dec_d,
   input  logic [6:0]        dec_seg,
   output logic [6:0]        seg,
   output logic [NDIG-1:0]   an,
   output logic              frame,
   output logic              pending
);

   localparam int unsigned CntW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int unsigned IdxW = $clog2(NDIG);
   localparam logic [CntW-1:0] CntMax = CntW'(PRESC - 1);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(NDIG - 1);

   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [4*NDIG-1:0] buf_q, buf_d;
   logic [4*NDIG-1:0] disp_q, disp_d;
   logic              pend_q, pend_d;
   logic [6:0]        seg_q, seg_d;
   logic [NDIG-1:0]   an_q, an_d;
   logic              frame_q;

   logic              tick;
   logic              wrap;
   logic              blank;
   logic [NDIG-1:0]   upper_zero;

   assign tick = (cnt_q == CntMax);
   assign wrap = tick && (idx_q == IdxMax);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end
   end

   // Double buffer: disp only moves at a frame wrap; a load on that same cycle stays pending.
   always_comb begin
      buf_d  = load ? data : buf_q;
      disp_d = (wrap && pend_q) ? buf_q : disp_q;
      pend_d = pend_q;
      if (load) begin
         pend_d = 1'b1;
      end else if (wrap) begin
         pend_d = 1'b0;
      end
   end

   always_comb begin
      dec_d = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (idx_q == IdxW'(i)) begin
            dec_d = disp_q[4*i +: 4];
         end
      end
   end

   // upper_zero[i]: digits NDIG-1 down to i are all zero.
   always_comb begin
      upper_zero = '0;
      upper_zero[NDIG-1] = (disp_q[4*(NDIG-1) +: 4] == 4'd0);
      for (int i = int'(NDIG) - 2; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
      end
   end

   always_comb begin
      blank = lzb && (idx_q != '0) && upper_zero[idx_q];
      an_d  = '1;
      seg_d = '0;
      if (!blank) begin
         seg_d = dec_seg;
         for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == IdxW'(i)) begin
               an_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         disp_q  <= '0;
         pend_q  <= 1'b0;
         seg_q   <= '0;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= wrap;
      end
   end

   assign seg     = seg_q;
   assign an      = an_q;
   assign frame   = frame_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: directed scenarios plus random loads, checked against
// a time-indexed model (slot = floor(k/PRESC) mod NDIG, k = edges since reset).
module tb_bcd_scan_ctrl;

   localparam int N = 4;
   localparam int P = 4;
   localparam int F = N * P;

   logic        clk = 1'b0;
   logic        reset, load, lzb;
   logic [15:0] data;
   logic [3:0]  dec_d;
   logic [6:0]  dec_seg, seg;
   logic [3:0]  an;
   logic        frame, pending;

   logic        reset1;
   logic [3:0]  dec_d1;
   logic [6:0]  dec_seg1, seg1;
   logic [3:0]  an1;
   logic        frame1, pending1;

   int total = 0;
   int bad   = 0;

   // model state (state after k edges since the last reset edge)
   int          k = 0;
   logic [15:0] m_disp = '0, m_buf = '0;
   logic        m_pend = 1'b0;
   logic        cur_lzb = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
      endcase
   endfunction

   assign dec_seg  = seg7(dec_d);
   assign dec_seg1 = seg7(dec_d1);

   bcd_scan_ctrl #(.NDIG(N), .PRESC(P)) dut (
      .clk(clk), .reset(reset), .load(load), .data(data), .lzb(lzb), .dec_d(dec_d),
      .dec_seg(dec_seg), .seg(seg), .an(an), .frame(frame), .pending(pending)
   );

   bcd_scan_ctrl #(.NDIG(N), .PRESC(1)) dut1 (
      .clk(clk), .reset(reset1), .load(1'b0), .data(16'h0000), .lzb(1'b0), .dec_d(dec_d1),
      .dec_seg(dec_seg1), .seg(seg1), .an(an1), .frame(frame1), .pending(pending1)
   );

   // One clock edge: predict registered outputs from the pre-edge model, then compare.
   task automatic step(input logic ld, input logic [15:0] dt, input logic lz, input logic rs);
      logic [6:0]  e_seg;
      logic [3:0]  e_an, e_dd;
      logic        e_frame;
      logic [15:0] n_disp, n_buf;
      logic        n_pend, wrapc, blank;
      int          slot, n_k;
      load = ld; data = dt; lzb = lz; reset = rs;
      if (rs) begin
         e_seg = '0; e_an = 4'hF; e_frame = 1'b0;
         n_disp = '0; n_buf = '0; n_pend = 1'b0; n_k = 0;
      end else begin
         slot  = (k / P) % N;
         wrapc = (k % F) == F - 1;
         blank = lz && slot != 0 && ((m_disp >> (4 * slot)) == 16'd0);
         e_an  = blank ? 4'hF : ~(4'(1 << slot));
         e_seg = blank ? 7'd0 : seg7(4'((m_disp >> (4 * slot)) & 16'hF));
         e_frame = wrapc;
         n_disp = (wrapc && m_pend) ? m_buf : m_disp;
         n_buf  = ld ? dt : m_buf;
         n_pend = ld ? 1'b1 : (wrapc ? 1'b0 : m_pend);
         n_k    = k + 1;
      end
      e_dd = 4'((n_disp >> (4 * ((n_k / P) % N))) & 16'hF);
      @(posedge clk);
      #1;
      total++;
      assert (seg === e_seg) else begin
         bad++; $error("FAIL seg k=%0d got=%h exp=%h", n_k, seg, e_seg);
      end
      total++;
      assert (an === e_an) else begin
         bad++; $error("FAIL an k=%0d got=%b exp=%b", n_k, an, e_an);
      end
      total++;
      assert (frame === e_frame) else begin
         bad++; $error("FAIL frame k=%0d got=%b exp=%b", n_k, frame, e_frame);
      end
      total++;
      assert (pending === n_pend) else begin
         bad++; $error("FAIL pending k=%0d got=%b exp=%b", n_k, pending, n_pend);
      end
      total++;
      assert (dec_d === e_dd) else begin
         bad++; $error("FAIL dec_d k=%0d got=%h exp=%h", n_k, dec_d, e_dd);
      end
      k = n_k; m_disp = n_disp; m_buf = n_buf; m_pend = n_pend;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, cur_lzb, 1'b0);
   endtask

   initial begin
      reset1 = 1'b1;
      // 1: reset and free-running scan
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      idle(40);
      // 2: mid-frame load
      idle(3);
      step(1'b1, 16'h1234, cur_lzb, 1'b0);
      idle(40);
      // 3: leading-zero blanking
      cur_lzb = 1'b1;
      step(1'b1, 16'h0070, cur_lzb, 1'b0);
      idle(40);
      step(1'b1, 16'h0000, cur_lzb, 1'b0);
      idle(40);
      cur_lzb = 1'b0;
      idle(20);
      // 4: back-to-back loads, last wins
      step(1'b1, 16'h1111, cur_lzb, 1'b0);
      step(1'b1, 16'h2222, cur_lzb, 1'b0);
      idle(40);
      // 5: load coinciding with wrap while pending
      while (k % F != 2) idle(1);
      step(1'b1, 16'h9999, cur_lzb, 1'b0);
      while (k % F != F - 1) idle(1);
      step(1'b1, 16'h5555, cur_lzb, 1'b0);
      idle(40);
      // 6: reset during slot 2 with data pending
      while ((k / P) % N != 2) idle(1);
      step(1'b1, 16'h4321, cur_lzb, 1'b0);
      step(1'b0, 16'h0000, cur_lzb, 1'b1);
      idle(20);
      // random phase
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) cur_lzb = ~cur_lzb;
         if ($urandom_range(0, 199) == 0) step(1'b0, 16'h0000, cur_lzb, 1'b1);
         else if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0)
               step(1'b1, 16'($urandom_range(0, 255)), cur_lzb, 1'b0);
            else
               step(1'b1, 16'($urandom), cur_lzb, 1'b0);
         end else idle(1);
      end
      // PRESC=1 instance: one slot per cycle, frame every 4 cycles
      @(posedge clk);
      #1;
      reset1 = 1'b0;
      total++;
      assert (an1 === 4'hF) else begin
         bad++; $error("FAIL p1_reset_an got=%b exp=%b", an1, 4'hF);
      end
      for (int j = 0; j < 12; j++) begin
         @(posedge clk);
         #1;
         total++;
         assert (an1 === ~(4'(1 << (j % N)))) else begin
            bad++; $error("FAIL p1_an j=%0d got=%b exp=%b", j, an1, ~(4'(1 << (j % N))));
         end
         total++;
         assert (frame1 === ((j % N) == N - 1)) else begin
            bad++; $error("FAIL p1_frame j=%0d got=%b exp=%b", j, frame1, (j % N) == N - 1);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
